version_writer: RTL and testbench

Write-side companion of the multi-version read router: owns `VERSION_NUM` versioned data slots and drives the flattened `versions`/`dataInputs` buses that the router consumes. Each accepted write is stamped with a monotonically increasing version number and placed in a free slot or over the oldest one. A multi-cycle scan FSM selects the victim slot. An optional pin guard stops the writer from evicting a version that live readers still need.

---
 rtl/version_pkg.sv | 26 ++
 rtl/version_writer_scan.sv | 107 ++++++++++
 rtl/version_writer.sv | 148 ++++++++++++++
 tb/tb_version_writer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/version_pkg.sv
// version_pkg
//   Definitions shared by the multi-version read router and version_writer.
//   - wr_state_t     : writer FSM states (IDLE, SCAN, WAIT, COMMIT)
//   - VERSION_NONE   : version 0, reserved to mean "no version"
//   - slot_entry_t   : one versioned data slot (valid, version, data)
package version_pkg;

    localparam int unsigned SLOT_VERSION_WIDTH = 4;
    localparam int unsigned SLOT_DATA_WIDTH    = 32;

    localparam logic [SLOT_VERSION_WIDTH-1:0] VERSION_NONE = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic                          valid;
        logic [SLOT_VERSION_WIDTH-1:0] version;
        logic [SLOT_DATA_WIDTH-1:0]    data;
    } slot_entry_t;

endpackage

// File: rtl/version_writer_scan.sv
// version_scan
//   Walks the slots one per cycle while i_active is high and picks the
//   victim: lowest-index invalid slot, otherwise the slot holding the
//   smallest version. Also tracks the second-smallest version for the
//   pin guard.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     i_active        : FSM is in SCAN; index advances each cycle
//     i_slotValid     : per-slot valid flags
//     i_slotVersions  : flattened slot versions
//     o_scanDone      : current cycle inspects the last slot
//     o_victimIdx     : chosen victim slot
//     o_victimInvalid : victim slot is currently invalid
//     o_secondMin     : second-smallest valid version seen
module version_scan
    import version_pkg::*;
#(
    parameter int unsigned VERSION_WIDTH = 4,
    parameter int unsigned VERSION_NUM   = 4,
    parameter int unsigned IDX_W         = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_active,
    input  logic [VERSION_NUM-1:0]           i_slotValid,
    input  logic [VERSION_WIDTH*VERSION_NUM-1:0] i_slotVersions,
    output logic                             o_scanDone,
    output logic [IDX_W-1:0]                 o_victimIdx,
    output logic                             o_victimInvalid,
    output logic [VERSION_WIDTH-1:0]         o_secondMin
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VERSION_NUM - 1);

    logic [IDX_W-1:0]         r_idx;
    logic                     r_foundInv;
    logic [IDX_W-1:0]         r_invIdx;
    logic [IDX_W-1:0]         r_minIdx;
    logic [VERSION_WIDTH-1:0] r_minVer;
    logic [VERSION_WIDTH-1:0] r_secMin;

    logic                     w_curValid;
    logic [VERSION_WIDTH-1:0] w_curVer;
    logic                     w_foundInv;
    logic [IDX_W-1:0]         w_invIdx;
    logic [IDX_W-1:0]         w_minIdx;
    logic [VERSION_WIDTH-1:0] w_minVer;
    logic [VERSION_WIDTH-1:0] w_secMin;

    // Tracker values including the slot inspected this cycle, so the final
    // decision is available combinationally during the last SCAN cycle.
    // Outside SCAN they fall back to the registered (complete) result.
    always_comb begin
        w_curValid = i_slotValid[r_idx];
        w_curVer   = i_slotVersions[r_idx*VERSION_WIDTH +: VERSION_WIDTH];
        w_foundInv = r_foundInv;
        w_invIdx   = r_invIdx;
        w_minIdx   = r_minIdx;
        w_minVer   = r_minVer;
        w_secMin   = r_secMin;
        if (i_active) begin
            if (r_idx == '0) begin
                w_foundInv = 1'b0;
                w_invIdx   = '0;
                w_minIdx   = '0;
                w_minVer   = '1;
                w_secMin   = '1;
            end
            if (!w_curValid) begin
                if (!w_foundInv) begin
                    w_foundInv = 1'b1;
                    w_invIdx   = r_idx;
                end
            end else if (w_curVer < w_minVer) begin
                w_secMin = w_minVer;
                w_minVer = w_curVer;
                w_minIdx = r_idx;
            end else if (w_curVer < w_secMin) begin
                w_secMin = w_curVer;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_foundInv <= 1'b0;
            r_invIdx   <= '0;
            r_minIdx   <= '0;
            r_minVer   <= '1;
            r_secMin   <= '1;
        end else if (i_active) begin
            r_idx      <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            r_foundInv <= w_foundInv;
            r_invIdx   <= w_invIdx;
            r_minIdx   <= w_minIdx;
            r_minVer   <= w_minVer;
            r_secMin   <= w_secMin;
        end
    end

    assign o_scanDone      = i_active && (r_idx == LAST_IDX);
    assign o_victimIdx     = w_foundInv ? w_invIdx : w_minIdx;
    assign o_victimInvalid = w_foundInv;
    assign o_secondMin     = w_secMin;

endmodule

// File: rtl/version_writer.sv
// version_writer
//   Write side of the multi-version store. Each accepted write gets the next
//   version number and lands in a free slot or over the oldest one, chosen
//   by a VERSION_NUM-cycle scan (version_scan).
//   Optional feature macro: VERSION_WRITER_PIN_EN enables the pin guard
//   (WAIT state) that holds a write while minLiveVersion readers still need
//   the version that would be evicted.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     wrValid/wrData    : write request and its data
//     wrReady           : request can be accepted
//     wrDone/wrVersion  : commit pulse and the version it assigned
//     minLiveVersion    : oldest version held by a live reader (0 = none)
//     versions          : slot i version at [i*VERSION_WIDTH +: VERSION_WIDTH]
//     dataInputs        : slot i data at [i*DATA_WIDTH +: DATA_WIDTH]
//     exhausted         : version space used up (sticky)
module version_writer
    import version_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned VERSION_WIDTH = 4,
    parameter int unsigned VERSION_NUM   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wrValid,
    input  logic [DATA_WIDTH-1:0]                wrData,
    output logic                                 wrReady,
    output logic                                 wrDone,
    output logic [VERSION_WIDTH-1:0]             wrVersion,
    input  logic [VERSION_WIDTH-1:0]             minLiveVersion,
    output logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
    output logic [DATA_WIDTH*VERSION_NUM-1:0]    dataInputs,
    output logic                                 exhausted
);

    localparam int unsigned IDX_W = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1;

    slot_entry_t              r_slots [VERSION_NUM];
    wr_state_t                r_state;
    logic [VERSION_WIDTH-1:0] r_count;
    logic [VERSION_WIDTH-1:0] r_wrVersion;
    logic [DATA_WIDTH-1:0]    r_wrData;
    logic                     r_wrDone;
    logic                     r_exhausted;

    logic [VERSION_NUM-1:0]   w_slotValid;
    logic                     w_scanDone;
    logic [IDX_W-1:0]         w_victimIdx;
    logic                     w_victimInvalid;
    logic [VERSION_WIDTH-1:0] w_secondMin;
    logic [VERSION_WIDTH-1:0] w_newVersion;
    logic                     w_safe;

    version_scan #(
        .VERSION_WIDTH (VERSION_WIDTH),
        .VERSION_NUM   (VERSION_NUM),
        .IDX_W         (IDX_W)
    ) u_scan (
        .clk             (clk),
        .rst             (rst),
        .i_active        (r_state == ST_SCAN),
        .i_slotValid     (w_slotValid),
        .i_slotVersions  (versions),
        .o_scanDone      (w_scanDone),
        .o_victimIdx     (w_victimIdx),
        .o_victimInvalid (w_victimInvalid),
        .o_secondMin     (w_secondMin)
    );

`ifdef VERSION_WRITER_PIN_EN
    // Evicting the smallest version is only harmful if a live reader might
    // still need it, i.e. the next-oldest version is not yet below the pin.
    assign w_safe = w_victimInvalid
                 || (w_secondMin < minLiveVersion)
                 || (minLiveVersion == VERSION_WIDTH'(VERSION_NONE));
`else
    logic w_unused_pin;
    assign w_unused_pin = ^{minLiveVersion, w_secondMin, w_victimInvalid};
    assign w_safe       = 1'b1;
`endif

    assign w_newVersion = r_count + VERSION_WIDTH'(1);

    always_comb begin
        versions    = '0;
        dataInputs  = '0;
        w_slotValid = '0;
        for (int unsigned i = 0; i < VERSION_NUM; i++) begin
            versions[i*VERSION_WIDTH +: VERSION_WIDTH] = VERSION_WIDTH'(r_slots[i].version);
            dataInputs[i*DATA_WIDTH +: DATA_WIDTH]     = DATA_WIDTH'(r_slots[i].data);
            w_slotValid[i]                             = r_slots[i].valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_wrVersion <= '0;
            r_wrData    <= '0;
            r_wrDone    <= 1'b0;
            r_exhausted <= 1'b0;
            for (int unsigned i = 0; i < VERSION_NUM; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            r_wrDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wrValid && !r_exhausted) begin
                        r_wrData <= wrData;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_scanDone) begin
                        r_state <= w_safe ? ST_COMMIT : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_safe) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_slots[w_victimIdx].valid   <= 1'b1;
                    r_slots[w_victimIdx].version <= SLOT_VERSION_WIDTH'(w_newVersion);
                    r_slots[w_victimIdx].data    <= SLOT_DATA_WIDTH'(r_wrData);
                    r_count     <= w_newVersion;
                    r_wrVersion <= w_newVersion;
                    r_wrDone    <= 1'b1;
                    if (w_newVersion == '1) begin
                        r_exhausted <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wrReady   = (r_state == ST_IDLE) && !r_exhausted;
    assign wrDone    = r_wrDone;
    assign wrVersion = r_wrVersion;
    assign exhausted = r_exhausted;

endmodule

// File: tb/tb_version_writer.sv
`timescale 1ns/1ps
module tb_version_writer;

    localparam int VN = 4;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         wrValid = 1'b0;
    logic [31:0]  wrData  = '0;
    logic [3:0]   minLive = '0;
    logic         wrReady;
    logic         wrDone;
    logic [3:0]   wrVersion;
    logic [15:0]  versions;
    logic [127:0] dataInputs;
    logic         exhausted;

    version_writer #(
        .DATA_WIDTH    (32),
        .VERSION_WIDTH (4),
        .VERSION_NUM   (VN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wrValid        (wrValid),
        .wrData         (wrData),
        .wrReady        (wrReady),
        .wrDone         (wrDone),
        .wrVersion      (wrVersion),
        .minLiveVersion (minLive),
        .versions       (versions),
        .dataInputs     (dataInputs),
        .exhausted      (exhausted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    int ndone    = 0;

    typedef struct {
        logic [3:0]   ver;
        logic [15:0]  vers;
        logic [127:0] data;
        bit           exh;
        int           due;
    } exp_t;

    exp_t sb[$];

    logic [3:0]  m_ver  [VN];
    logic [31:0] m_data [VN];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] pack_v();
        logic [15:0] v = '0;
        for (int i = 0; i < VN; i++) v[i*4 +: 4] = m_ver[i];
        return v;
    endfunction

    function automatic logic [127:0] pack_d();
        logic [127:0] d = '0;
        for (int i = 0; i < VN; i++) d[i*32 +: 32] = m_data[i];
        return d;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < VN; i++) begin
            m_ver[i]  = '0;
            m_data[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wrValid = 1'b0;
        minLive = '0;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Monitor: every wrDone pops the next expected commit and checks it.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wrDone) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_wrDone: got wrVersion %0d expected no commit", wrVersion);
            end else begin
                e = sb.pop_front();
                chk("wrVersion", wrVersion, e.ver);
                chk("versions_bus", versions, e.vers);
                chk("dataInputs_bus", dataInputs, e.data);
                chk("exhausted_on_done", exhausted, e.exh);
                chk("wrReady_on_done", wrReady, !e.exh);
                if (e.due >= 0) chk("done_cycle", cyc, e.due);
            end
            ndone++;
        end
    end

    // lat = clock edges from the accept edge to the commit edge (wrDone is
    // then high in the following cycle); negative skips the timing check.
    task automatic issue(input logic [31:0] d, input int slot, input logic [3:0] ver, input int lat);
        exp_t e;
        int k = 0;
        while (!wrReady && k < 40) begin
            tick();
            k++;
        end
        chk("ready_before_issue", wrReady, 1'b1);
        wrValid      = 1'b1;
        wrData       = d;
        m_ver[slot]  = ver;
        m_data[slot] = d;
        e.ver  = ver;
        e.vers = pack_v();
        e.data = pack_d();
        e.exh  = (ver == 4'hF);
        e.due  = (lat < 0) ? -1 : cyc + 1 + lat;
        sb.push_back(e);
        tick();
        wrValid = 1'b0;
        wrData  = ~d;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (ndone < target && k < 40) begin
            tick();
            k++;
        end
        chk("done_arrived", ndone, target);
    endtask

    task automatic wr(input logic [31:0] d, input int slot, input logic [3:0] ver);
        int t = ndone + 1;
        issue(d, slot, ver, 5);
        wait_done(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        clear_model();
        do_reset();
        repeat (3) tick();
        chk("reset_versions", versions, 16'h0);
        chk("reset_data", dataInputs, 128'h0);
        chk("reset_wrReady", wrReady, 1'b1);
        chk("reset_wrDone", wrDone, 1'b0);
        chk("reset_exhausted", exhausted, 1'b0);
        chk("reset_wrVersion", wrVersion, 4'h0);

        wr(32'hA0, 0, 4'd1);
        wr(32'hA1, 1, 4'd2);
        wr(32'hA2, 2, 4'd3);
        wr(32'hA3, 3, 4'd4);
        chk("four_writes_versions", versions, 16'h4321);
        wr(32'hA4, 0, 4'd5);
        chk("fifth_versions", versions, 16'h4325);
        chk("fifth_slot0_data", dataInputs[31:0], 32'hA4);
        chk("fifth_slot3_data", dataInputs[127:96], 32'hA3);

`ifdef VERSION_WRITER_PIN_EN
        do_reset();
        wr(32'hA0, 0, 4'd1);
        wr(32'hA1, 1, 4'd2);
        wr(32'hA2, 2, 4'd3);
        wr(32'hA3, 3, 4'd4);
        minLive = 4'd2;
        t = ndone;
        issue(32'hB0, 0, 4'd5, -1);
        repeat (12) tick();
        chk("pin_hold_no_done", ndone, t);
        chk("pin_hold_busy", wrReady, 1'b0);
        chk("pin_hold_versions", versions, 16'h4321);
        minLive = 4'd3;
        tick();
        chk("pin_release_not_early", ndone, t);
        tick();
        chk("pin_release_done", ndone, t + 1);
        minLive = 4'd0;
        chk("pin_versions", versions, 16'h4325);
        chk("pin_slot0_data", dataInputs[31:0], 32'hB0);
`endif

        do_reset();
        for (int n = 1; n <= 15; n++) wr(32'hC00 + n, (n - 1) % 4, 4'(n));
        chk("exh_wrVersion", wrVersion, 4'hF);
        chk("exh_flag", exhausted, 1'b1);
        t = ndone;
        wrValid = 1'b1;
        wrData  = 32'hDEAD;
        repeat (10) tick();
        chk("exh_ready_low", wrReady, 1'b0);
        chk("exh_no_done", ndone, t);
        chk("exh_versions", versions, 16'hCFED);
        chk("exh_data", dataInputs, {32'hC0C, 32'hC0F, 32'hC0E, 32'hC0D});
        wrValid = 1'b0;

        do_reset();
        wr(32'hD0, 0, 4'd1);
        issue(32'hD1, 1, 4'd2, 5);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_versions", versions, 16'h0);
        chk("abort_data", dataInputs, 128'h0);
        chk("abort_wrReady", wrReady, 1'b1);
        chk("abort_wrDone", wrDone, 1'b0);
        chk("abort_wrVersion", wrVersion, 4'h0);
        chk("abort_exhausted", exhausted, 1'b0);
        clear_model();
        tick();
        rst = 1'b0;
        tick();
        wr(32'hE0, 0, 4'd1);
        chk("after_abort_versions", versions, 16'h0001);
        chk("after_abort_data", dataInputs, 128'hE0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
